// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: immediate format codes, opcodes and auto-decode helper
package imm_gen_pipe_pkg;
    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_S     = 3'd1;
    localparam logic [2:0] IMM_B     = 3'd2;
    localparam logic [2:0] IMM_J     = 3'd3;
    localparam logic [2:0] IMM_U     = 3'd4;
    localparam logic [2:0] IMM_SHAMT = 3'd5;
    localparam logic [2:0] IMM_ZIMM  = 3'd6;
    localparam logic [2:0] IMM_NONE  = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic [2:0] auto_fmt(input logic [6:0] op, input logic [2:0] f3);
        logic [2:0] f;
        case (op)
            OP_LOAD, OP_JALR: f = IMM_I;
            OP_IMM:           f = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OP_STORE:         f = IMM_S;
            OP_BRANCH:        f = IMM_B;
            OP_JAL:           f = IMM_J;
            OP_LUI, OP_AUIPC: f = IMM_U;
            OP_SYSTEM:        f = f3[2] ? IMM_ZIMM : IMM_NONE;
            default:          f = IMM_NONE;
        endcase
        return f;
    endfunction
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction and extension for one format
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm_ext,
    output logic            no_imm
);
    logic [63:0] full;

    // build the 64-bit extended value, then truncate to XLEN
    always_comb begin
        full = 64'd0;
        case (fmt)
            IMM_I:     full = {{52{instr[31]}}, instr[31:20]};
            IMM_S:     full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     full = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:     full = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:     full = {{32{instr[31]}}, instr[31:12], 12'd0};
            IMM_SHAMT: full = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
            IMM_ZIMM:  full = {59'd0, instr[19:15]};
            default:   full = 64'd0;
        endcase
    end

    assign imm_ext = XLEN'(full);
    assign no_imm  = (fmt == IMM_NONE);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with pc target and skid-buffered handshake
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] pc_target,
    output logic [2:0]      imm_type,
    output logic            no_imm
);
    logic [2:0]      fmt;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] tgt;
    logic            no;
    logic            in_xfer;
    logic            o_free;
    logic            k_next;
    logic            ready_q;
    logic            k_valid;
    logic [XLEN-1:0] k_imm;
    logic [XLEN-1:0] k_tgt;
    logic [2:0]      k_type;
    logic            k_no;

    assign fmt = AUTO_DECODE ? auto_fmt(instr[6:0], instr[14:12]) : imm_src;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr  (instr[31:7]),
        .fmt    (fmt),
        .imm_ext(ext),
        .no_imm (no)
    );

    assign tgt      = pc + ext;
    assign in_xfer  = in_valid & in_ready;
    assign o_free   = ~out_valid | out_ready;
    // skid stays occupied only when the output stage is stalled
    assign k_next   = o_free ? 1'b0 : (k_valid | in_xfer);
    // ready comes from a register, so out_ready never reaches in_ready combinationally
    assign in_ready = ready_q & ~reset;

    // output register fed from skid first, else from the input; skid catches input when output stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            imm_ext   <= '0;
            pc_target <= '0;
            imm_type  <= IMM_NONE;
            no_imm    <= 1'b1;
            k_valid   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            if (o_free) begin
                out_valid <= k_valid | in_xfer;
                if (k_valid) begin
                    imm_ext   <= k_imm;
                    pc_target <= k_tgt;
                    imm_type  <= k_type;
                    no_imm    <= k_no;
                end else if (in_xfer) begin
                    imm_ext   <= ext;
                    pc_target <= tgt;
                    imm_type  <= fmt;
                    no_imm    <= no;
                end
            end else if (in_xfer) begin
                k_imm  <= ext;
                k_tgt  <= tgt;
                k_type <= fmt;
                k_no   <= no;
            end
            k_valid <= k_next;
            ready_q <= ~k_next;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for 32-bit explicit-format and 64-bit auto-decode instances
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  typ;
        logic        no;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v32 = 0, r32, ov32, or32 = 1, n32;
    logic [31:0] i32 = 0, p32 = 0, e32, t32;
    logic [2:0]  s32 = 0, ty32;
    logic        v64 = 0, r64, ov64, or64 = 1, n64;
    logic [31:0] i64 = 0;
    logic [63:0] p64 = 0, e64, t64;
    logic [2:0]  s64 = 0, ty64;

    int tests = 0;
    int fails = 0;
    int popped64 = 0;
    exp_t q32[$];
    exp_t q64[$];

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) d32 (
        .clk(clk), .reset(rst), .in_valid(v32), .in_ready(r32), .instr(i32), .pc(p32),
        .imm_src(s32), .out_valid(ov32), .out_ready(or32), .imm_ext(e32), .pc_target(t32),
        .imm_type(ty32), .no_imm(n32)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) d64 (
        .clk(clk), .reset(rst), .in_valid(v64), .in_ready(r64), .instr(i64), .pc(p64),
        .imm_src(s64), .out_valid(ov64), .out_ready(or64), .imm_ext(e64), .pc_target(t64),
        .imm_type(ty64), .no_imm(n64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] dec(input logic [31:0] i);
        logic [2:0] f3 = i[14:12];
        case (i[6:0])
            7'h03, 7'h67: return 3'd0;
            7'h13:        return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h6F:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h73:        return i[14] ? 3'd6 : 3'd7;
            default:      return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ext(input logic [31:0] i, input logic [2:0] f, input bit w64);
        logic signed [63:0] v;
        case (f)
            3'd0:    v = $signed(i[31:20]);
            3'd1:    v = $signed({i[31:25], i[11:7]});
            3'd2:    v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            3'd3:    v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            3'd4:    v = $signed({i[31:12], 12'h000});
            3'd5:    v = w64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            3'd6:    v = {59'd0, i[19:15]};
            default: v = 64'sd0;
        endcase
        return w64 ? v : {32'd0, v[31:0]};
    endfunction

    function automatic exp_t mk(input logic [31:0] ins, input logic [63:0] p, input logic [2:0] src,
                                input bit auto, input bit w64);
        exp_t e;
        logic [2:0] f = auto ? dec(ins) : src;
        logic [31:0] lo;
        e.imm = ext(ins, f, w64);
        lo = p[31:0] + e.imm[31:0];
        e.tgt = w64 ? p + e.imm : {32'd0, lo};
        e.typ = f;
        e.no  = (f == 3'd7);
        return e;
    endfunction

    // scoreboard: compare the head entry whenever output is valid, pop on transfer, push on input transfer
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            q64.delete();
        end else begin
            if (ov32) begin
                check("q32_nonempty", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    check("imm32", {32'd0, e32}, q32[0].imm);
                    check("tgt32", {32'd0, t32}, q32[0].tgt);
                    check("typ32", 64'(ty32), 64'(q32[0].typ));
                    check("no32", 64'(n32), 64'(q32[0].no));
                    if (or32) void'(q32.pop_front());
                end
            end
            if (v32 && r32) q32.push_back(mk(i32, {32'd0, p32}, s32, 1'b0, 1'b0));
            if (ov64) begin
                check("q64_nonempty", 64'(q64.size() != 0), 64'd1);
                if (q64.size() != 0) begin
                    check("imm64", e64, q64[0].imm);
                    check("tgt64", t64, q64[0].tgt);
                    check("typ64", 64'(ty64), 64'(q64[0].typ));
                    check("no64", 64'(n64), 64'(q64[0].no));
                    if (or64) begin
                        void'(q64.pop_front());
                        popped64++;
                    end
                end
            end
            if (v64 && r64) q64.push_back(mk(i64, p64, 3'd0, 1'b1, 1'b1));
        end
    end

    task automatic send32(input logic [31:0] ins, input logic [31:0] p, input logic [2:0] src);
        int n = 0;
        v32 = 1'b1; i32 = ins; p32 = p; s32 = src;
        do begin
            @(negedge clk);
            n++;
        end while (!r32 && n < 100);
        check("send32_accepted", 64'(r32), 64'd1);
        @(posedge clk); #1;
        v32 = 1'b0;
    endtask

    task automatic send64(input logic [31:0] ins, input logic [63:0] p);
        int n = 0;
        v64 = 1'b1; i64 = ins; p64 = p;
        do begin
            @(negedge clk);
            n++;
        end while (!r64 && n < 100);
        check("send64_accepted", 64'(r64), 64'd1);
        @(posedge clk); #1;
        v64 = 1'b0;
    endtask

    logic [6:0] ops [11] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F};

    initial begin
        int p0;
        int sent;
        int cyc;
        bit acc;
        logic [31:0] r;
        time t0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready64", 64'(r64), 64'd0);
        check("rst_in_ready32", 64'(r32), 64'd0);
        check("rst_out_valid64", 64'(ov64), 64'd0);
        check("rst_imm64", e64, 64'd0);
        check("rst_tgt64", t64, 64'd0);
        check("rst_type64", 64'(ty64), 64'd7);
        check("rst_no64", 64'(n64), 64'd1);
        check("rst_out_valid32", 64'(ov32), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready64", 64'(r64), 64'd1);
        check("post_rst_ready32", 64'(r32), 64'd1);
        @(posedge clk); #1;

        send32(32'hFE000EE3, 32'h100, 3'd2);
        @(negedge clk);
        check("beq_valid", 64'(ov32), 64'd1);
        check("beq_imm", {32'd0, e32}, 64'hFFFFFFFC);
        check("beq_tgt", {32'd0, t32}, 64'h000000FC);
        check("beq_type", 64'(ty32), 64'd2);
        check("beq_no", 64'(n32), 64'd0);
        @(posedge clk); #1;
        send32(32'h02000013, 32'hFFFFFFF0, 3'd0);
        @(negedge clk);
        check("wrap32_tgt", {32'd0, t32}, 64'h00000010);
        @(posedge clk); #1;
        for (int f = 0; f < 8; f++) send32(32'hF0F0A5A5, 32'h1000 + 32'(f), 3'(f));
        send32(32'h7FFFFFFF, 32'h2000, 3'd5);
        @(negedge clk);
        check("shamt32_imm", {32'd0, e32}, 64'd31);
        @(posedge clk); #1;

        send64(32'h800002B7, 64'h10);
        @(negedge clk);
        check("lui_imm", e64, 64'hFFFFFFFF80000000);
        check("lui_type", 64'(ty64), 64'd4);
        @(posedge clk); #1;
        send64(32'h03F29293, 64'h20);
        @(negedge clk);
        check("slli_imm", e64, 64'd63);
        check("slli_type", 64'(ty64), 64'd5);
        @(posedge clk); #1;
        send64(32'h00000073, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        check("ecall_no", 64'(n64), 64'd1);
        check("ecall_imm", e64, 64'd0);
        check("ecall_tgt", t64, 64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #1;
        send64(32'h3400D073, 64'h40);
        @(negedge clk);
        check("csrrwi_imm", e64, 64'd1);
        check("csrrwi_type", 64'(ty64), 64'd6);
        @(posedge clk); #1;

        or64 = 1'b0;
        send64(32'h000010B7, 64'h100);
        send64(32'h000020B7, 64'h200);
        v64 = 1'b1; i64 = 32'h000030B7; p64 = 64'h300;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 64'(r64), 64'd0);
            check("bp_out_valid", 64'(ov64), 64'd1);
            check("bp_stall_imm", e64, 64'h1000);
        end
        @(posedge clk); #1;
        p0 = popped64;
        or64 = 1'b1;
        send64(32'h000030B7, 64'h300);
        send64(32'h000040B7, 64'h400);
        check("bp_drain3", 64'(popped64 - p0), 64'd3);
        @(posedge clk); #1;
        check("bp_drain4", 64'(popped64 - p0), 64'd4);
        check("bp_empty", 64'(q64.size()), 64'd0);

        or64 = 1'b0;
        send64(32'h000050B7, 64'h500);
        send64(32'h000060B7, 64'h600);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(r64), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", 64'(ov64), 64'd0);
        check("after_rst_ready", 64'(r64), 64'd1);
        or64 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("after_rst_no_stale", 64'(ov64), 64'd0);
        end
        @(posedge clk); #1;

        t0 = $time;
        for (int k = 0; k < 20; k++) begin
            r = $urandom();
            send64({r[31:7], ops[k % 11]}, {$urandom(), $urandom()});
        end
        check("throughput_cycles", 64'($time - t0), 64'd200);

        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            @(negedge clk);
            acc = v64 && r64;
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (acc || !v64) begin
                v64 = ($urandom_range(0, 3) != 0);
                r = $urandom();
                i64 = {r[31:7], ops[$urandom_range(0, 10)]};
                p64 = {$urandom(), $urandom()};
            end
            or64 = ($urandom_range(0, 3) != 0);
        end
        check("rand_sent", 64'(sent), 64'd10000);
        v64 = 1'b0;
        or64 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("final_q64_empty", 64'(q64.size()), 64'd0);
        check("final_q32_empty", 64'(q32.size()), 64'd0);
        check("final_out_valid", 64'(ov64), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
